// File: rtl/uart_loader.sv
// uart_loader: receives an 8N1 UART byte stream (16-bit big-endian word count N,
// then N big-endian 32-bit words) and writes the words into instruction memory,
// holding the CPU in reset until the load has finished.
// Ports: clk/reset (async, active-low); uart_on enables loading; rx is the serial line;
//   imem_we/imem_addr/imem_wdata form the one-cycle memory write; cpu_hold, done and
//   frame_err (sticky, set by a low stop bit) report status.
module uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_on,
  input  logic                  rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

  rx_state_t        r_rx_state, w_rx_next;
  logic             r_rx_s1, r_rx_s2, r_rx_prev;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_vld;
  logic [7:0]       r_byte;
  logic             w_tick_half, w_tick_bit;

  assign w_tick_half = (r_clk_cnt == CNT_W'(HALF - 1));
  assign w_tick_bit  = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rx_state <= RX_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      // Edge rather than level: after a dropped frame the line may still be low.
      RX_IDLE:  if (!r_rx_s2 && r_rx_prev) w_rx_next = RX_START;
      RX_START: if (w_tick_half) w_rx_next = r_rx_s2 ? RX_IDLE : RX_BITS;
      RX_BITS:  if (w_tick_bit && (r_bit_idx == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP:  if (w_tick_bit) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_byte_vld <= 1'b0;
      r_byte     <= '0;
      frame_err  <= 1'b0;
    end else begin
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_byte_vld <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
        end
        RX_START: r_clk_cnt <= w_tick_half ? '0 : r_clk_cnt + 1'b1;
        RX_BITS: begin
          r_clk_cnt <= w_tick_bit ? '0 : r_clk_cnt + 1'b1;
          if (w_tick_bit) begin
            r_shift   <= {r_rx_s2, r_shift[7:1]};  // LSB arrives first
            r_bit_idx <= r_bit_idx + 1'b1;
          end
        end
        RX_STOP: begin
          r_clk_cnt <= w_tick_bit ? '0 : r_clk_cnt + 1'b1;
          if (w_tick_bit) begin
            if (r_rx_s2) begin
              r_byte_vld <= 1'b1;
              r_byte     <= r_shift;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: r_clk_cnt <= '0;
      endcase
    end
  end

  // ---------------- loader ----------------
  typedef enum logic [2:0] {L_IDLE, L_LEN_HI, L_LEN_LO, L_DATA, L_DONE} ld_state_t;

  ld_state_t   r_ld_state, w_ld_next;
  logic [15:0] r_len;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_word;
  logic        w_accept, w_last_word, w_in_range;

  // A byte landing in the same cycle as uart_on dropping is discarded.
  assign w_accept    = r_byte_vld && uart_on;
  assign w_last_word = (r_word_idx == (r_len - 16'd1));
  assign w_in_range  = ({1'b0, r_word_idx} < DEPTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ld_state <= L_IDLE;
    else        r_ld_state <= w_ld_next;
  end

  always_comb begin
    w_ld_next = r_ld_state;
    case (r_ld_state)
      L_IDLE:   if (uart_on) w_ld_next = L_LEN_HI;
      L_LEN_HI: if (!uart_on) w_ld_next = L_IDLE;
                else if (w_accept) w_ld_next = L_LEN_LO;
      L_LEN_LO: if (!uart_on) w_ld_next = L_IDLE;
                else if (w_accept) w_ld_next = ({r_len[15:8], r_byte} == 16'd0) ? L_DONE : L_DATA;
      L_DATA:   if (!uart_on) w_ld_next = L_IDLE;
                else if (w_accept && (r_byte_idx == 2'd3) && w_last_word) w_ld_next = L_DONE;
      L_DONE:   w_ld_next = L_DONE;
      default:  w_ld_next = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      case (r_ld_state)
        L_IDLE: begin
          r_word_idx <= '0;
          r_byte_idx <= '0;
        end
        L_LEN_HI: if (w_accept) r_len[15:8] <= r_byte;
        L_LEN_LO: begin
          r_word_idx <= '0;
          r_byte_idx <= '0;
          if (w_accept) r_len[7:0] <= r_byte;
        end
        L_DATA: if (w_accept) begin
          r_word     <= {r_word[15:0], r_byte};
          r_byte_idx <= r_byte_idx + 1'b1;
          if (r_byte_idx == 2'd3) begin
            // Words beyond memory depth are consumed but never written.
            if (w_in_range) begin
              imem_we    <= 1'b1;
              imem_addr  <= r_word_idx[ADDR_WIDTH-1:0];
              imem_wdata <= {r_word, r_byte};
            end
            r_word_idx <= r_word_idx + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done     = (r_ld_state == L_DONE);
  assign cpu_hold = reset && ((r_ld_state == L_LEN_HI) || (r_ld_state == L_LEN_LO) ||
                              (r_ld_state == L_DATA)   || ((r_ld_state == L_IDLE) && uart_on));

endmodule

// File: tb/tb_uart_loader.sv
module tb_uart_loader;
  localparam int CPB = 4;
  localparam int AW  = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          uart_on = 1'b0;
  logic          rx = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold, done, frame_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];
  logic [7:0]  tx_q[$];

  uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .uart_on(uart_on), .rx(rx),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (reset === 1'b1 && imem_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(imem_we), 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e[32]));
        check("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic send_q();
    foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, with uart_on high to show cpu_hold is forced low in reset.
    uart_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("hold_on_release", 32'(cpu_hold), 32'd1);
    check("done_on_release", 32'(done), 32'd0);

    // Two-word load.
    exp_q.push_back({1'b0, 32'h12345678});
    exp_q.push_back({1'b1, 32'h9ABCDEF0});
    tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_q();
    wait_done("two_word_done");
    check("two_word_q_empty", exp_q.size(), 32'd0);
    check("two_word_hold", 32'(cpu_hold), 32'd0);
    // Bytes after DONE are ignored (any strobe trips the scoreboard).
    tx_q = '{8'h55, 8'h55, 8'h55, 8'h55};
    send_q();
    check("done_sticky", 32'(done), 32'd1);

    // Zero-length load.
    do_reset();
    tx_q = '{8'h00, 8'h00};
    send_q();
    check("zero_len_done", 32'(done), 32'd1);
    check("zero_len_hold", 32'(cpu_hold), 32'd0);

    // More words than memory depth: third word consumed silently.
    do_reset();
    exp_q.push_back({1'b0, 32'hA1A2A3A4});
    exp_q.push_back({1'b1, 32'hB1B2B3B4});
    tx_q = '{8'h00, 8'h03, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4,
             8'hC1, 8'hC2, 8'hC3, 8'hC4};
    send_q();
    wait_done("overflow_done");
    check("overflow_q_empty", exp_q.size(), 32'd0);

    // Framing error mid-word: byte dropped, assembly continues, flag sticky.
    do_reset();
    exp_q.push_back({1'b0, 32'h11223344});
    tx_q = '{8'h00, 8'h01, 8'h11, 8'h22};
    send_q();
    send_byte(8'hEE, 1'b0);
    check("ferr_set", 32'(frame_err), 32'd1);
    tx_q = '{8'h33, 8'h44};
    send_q();
    wait_done("ferr_done");
    check("ferr_sticky", 32'(frame_err), 32'd1);
    check("ferr_q_empty", exp_q.size(), 32'd0);

    // One-cycle glitch on an idle line must not produce a byte.
    do_reset();
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_ferr", 32'(frame_err), 32'd0);
    check("glitch_hold", 32'(cpu_hold), 32'd1);
    exp_q.push_back({1'b0, 32'hAABBCCDD});
    tx_q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_q();
    wait_done("glitch_done");
    check("glitch_q_empty", exp_q.size(), 32'd0);

    // Reset in the middle of a word discards the partial data.
    do_reset();
    exp_q.push_back({1'b0, 32'h01020304});
    tx_q = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_q();
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("midrst_we", 32'(imem_we), 32'd0);
    check("midrst_addr", 32'(imem_addr), 32'd0);
    check("midrst_wdata", imem_wdata, 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back({1'b0, 32'hCAFEBABE});
    tx_q = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send_q();
    wait_done("restart_done");
    check("restart_q_empty", exp_q.size(), 32'd0);

    // uart_on low for a whole frame: no writes, no hold, never done.
    uart_on = 1'b0;
    do_reset();
    check("off_hold_idle", 32'(cpu_hold), 32'd0);
    tx_q = '{8'h00, 8'h01, 8'h11, 8'h11, 8'h11, 8'h11};
    send_q();
    check("off_hold", 32'(cpu_hold), 32'd0);
    check("off_done", 32'(done), 32'd0);
    check("off_we", 32'(imem_we), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
